// File: rtl/req_ack_window_if.sv
// ----------------------------------------------------------------------------
// req_ack_win_if
// Bundles the handshake inputs and verdict outputs of req_ack_window_checker.
// The checker itself is a passive observer, so it takes the slave modport.
// The environment that drives req/ack and reads verdicts takes the master modport.
//
// Signals:
//   enable      0 holds every channel FSM in IDLE with no verdicts
//   clr         synchronous clear of FSMs, counters, stickies and causes
//   req, ack    per-channel handshake under observation
//   pass_pulse  1-cycle pulse per channel on a legal transaction
//   fail_pulse  1-cycle pulse per channel on any violation
//   err_sticky  per-channel flag set on fail, cleared by reset or clr
//   fail_cause  2 bits per channel: 1 early, 2 timeout, 3 protocol
//   pass_cnt    CNT_W bits per channel, saturating
//   fail_cnt    CNT_W bits per channel, saturating
//   busy        per-channel FSM in WAIT
// ----------------------------------------------------------------------------
interface req_ack_win_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic                      enable;
  logic                      clr;
  logic [NUM_CH-1:0]         req;
  logic [NUM_CH-1:0]         ack;
  logic [NUM_CH-1:0]         pass_pulse;
  logic [NUM_CH-1:0]         fail_pulse;
  logic [NUM_CH-1:0]         err_sticky;
  logic [2*NUM_CH-1:0]       fail_cause;
  logic [CNT_W*NUM_CH-1:0]   pass_cnt;
  logic [CNT_W*NUM_CH-1:0]   fail_cnt;
  logic [NUM_CH-1:0]         busy;

  modport master (
    output enable, clr, req, ack,
    input  pass_pulse, fail_pulse, err_sticky, fail_cause,
           pass_cnt, fail_cnt, busy
  );

  modport slave (
    input  enable, clr, req, ack,
    output pass_pulse, fail_pulse, err_sticky, fail_cause,
           pass_cnt, fail_cnt, busy
  );
endinterface

// File: rtl/req_ack_window_checker.sv
// ----------------------------------------------------------------------------
// req_ack_window_checker
// Multi-channel protocol checker. Each of NUM_CH independent req/ack
// handshakes must see ack within [MIN_LAT, MAX_LAT] edges after req is first
// sampled high. Each channel reports a registered pass/fail pulse, keeps
// saturating pass/fail counters, and records a sticky error flag and the
// cause of the most recent failure.
//
// Ports:
//   clk   sole clock, all state changes on posedge
//   rst   asynchronous, active-low reset
//   bus   req_ack_win_if.slave: enable, clr, req, ack in;
//         pass_pulse, fail_pulse, err_sticky, fail_cause, pass_cnt,
//         fail_cnt, busy out
//
// Optional feature macro: CHK_SVA_EN
//   When defined, a per-channel concurrent assertion re-checks the latency
//   window in simulation. Ports and RTL behaviour are identical either way.
// ----------------------------------------------------------------------------
module req_ack_window_checker #(
  parameter int NUM_CH  = 4,
  parameter int MIN_LAT = 1,
  parameter int MAX_LAT = 8,
  parameter int CNT_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  req_ack_win_if.slave   bus
);

  localparam int LAT_W = $clog2(MAX_LAT + 1);

  localparam logic [LAT_W-1:0] C_LAT_ONE = LAT_W'(1);
  localparam logic [LAT_W-1:0] C_LAT_MIN = LAT_W'(MIN_LAT);
  localparam logic [LAT_W-1:0] C_LAT_MAX = LAT_W'(MAX_LAT);

  localparam logic [1:0] C_CAUSE_NONE    = 2'd0;
  localparam logic [1:0] C_CAUSE_EARLY   = 2'd1;
  localparam logic [1:0] C_CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] C_CAUSE_PROTO   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  // Per-channel FSM state and latency counter
  state_t              r_state    [NUM_CH];
  state_t              w_state_nxt[NUM_CH];
  logic [LAT_W-1:0]    r_lat      [NUM_CH];
  logic [LAT_W-1:0]    w_lat_nxt  [NUM_CH];

  // Verdicts decided at the current edge, registered into the pulses
  logic [NUM_CH-1:0]   w_pass;
  logic [NUM_CH-1:0]   w_fail;
  logic [1:0]          w_cause    [NUM_CH];

  // Registered outputs
  logic [NUM_CH-1:0]         r_pass_pulse;
  logic [NUM_CH-1:0]         r_fail_pulse;
  logic [NUM_CH-1:0]         r_err_sticky;
  logic [2*NUM_CH-1:0]       r_fail_cause;
  logic [CNT_W*NUM_CH-1:0]   r_pass_cnt;
  logic [CNT_W*NUM_CH-1:0]   r_fail_cnt;
  logic [NUM_CH-1:0]         w_busy;

  // Counters stop at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    else    return v + CNT_W'(1);
  endfunction

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= S_IDLE;
        r_lat[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_lat[i]   <= w_lat_nxt[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and verdict decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_pass = '0;
    w_fail = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_lat_nxt[i]   = r_lat[i];
      w_cause[i]     = C_CAUSE_NONE;

      // clr and a disabled checker both park every channel in IDLE with no
      // verdict, whatever the handshake is doing this cycle.
      if (bus.clr || !bus.enable) begin
        w_state_nxt[i] = S_IDLE;
        w_lat_nxt[i]   = '0;
      end else begin
        unique case (r_state[i])
          S_IDLE: begin
            // ack without an outstanding request is always illegal, even
            // when req rises in the same cycle.
            if (bus.ack[i]) begin
              w_fail[i]  = 1'b1;
              w_cause[i] = C_CAUSE_PROTO;
            end else if (bus.req[i]) begin
              w_state_nxt[i] = S_WAIT;
              w_lat_nxt[i]   = C_LAT_ONE;
            end
          end

          S_WAIT: begin
            // ack is checked before the timeout so that an ack landing
            // exactly on MAX_LAT is still legal.
            if (bus.ack[i]) begin
              if (r_lat[i] >= C_LAT_MIN) begin
                w_pass[i] = 1'b1;
              end else begin
                w_fail[i]  = 1'b1;
                w_cause[i] = C_CAUSE_EARLY;
              end
              w_state_nxt[i] = S_RELEASE;
              w_lat_nxt[i]   = '0;
            end else if (!bus.req[i]) begin
              // Request withdrawn before it was acknowledged
              w_fail[i]      = 1'b1;
              w_cause[i]     = C_CAUSE_PROTO;
              w_state_nxt[i] = S_IDLE;
              w_lat_nxt[i]   = '0;
            end else if (r_lat[i] == C_LAT_MAX) begin
              w_fail[i]      = 1'b1;
              w_cause[i]     = C_CAUSE_TIMEOUT;
              w_state_nxt[i] = S_RELEASE;
              w_lat_nxt[i]   = '0;
            end else begin
              w_lat_nxt[i] = r_lat[i] + C_LAT_ONE;
            end
          end

          S_RELEASE: begin
            // Dropping req ends the transaction; an ack seen in the same
            // cycle is treated as the tail of the completed handshake.
            if (!bus.req[i]) begin
              w_state_nxt[i] = S_IDLE;
            end else if (bus.ack[i]) begin
              w_fail[i]  = 1'b1;
              w_cause[i] = C_CAUSE_PROTO;
            end
          end

          default: begin
            w_state_nxt[i] = S_IDLE;
            w_lat_nxt[i]   = '0;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Verdict registers: pulses, stickies, causes and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pass_pulse <= '0;
      r_fail_pulse <= '0;
      r_err_sticky <= '0;
      r_fail_cause <= '0;
      r_pass_cnt   <= '0;
      r_fail_cnt   <= '0;
    end else if (bus.clr) begin
      r_pass_pulse <= '0;
      r_fail_pulse <= '0;
      r_err_sticky <= '0;
      r_fail_cause <= '0;
      r_pass_cnt   <= '0;
      r_fail_cnt   <= '0;
    end else begin
      r_pass_pulse <= w_pass;
      r_fail_pulse <= w_fail;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_pass[i]) begin
          r_pass_cnt[i*CNT_W +: CNT_W] <= sat_inc(r_pass_cnt[i*CNT_W +: CNT_W]);
        end
        if (w_fail[i]) begin
          r_fail_cnt[i*CNT_W +: CNT_W] <= sat_inc(r_fail_cnt[i*CNT_W +: CNT_W]);
          r_err_sticky[i]              <= 1'b1;
          r_fail_cause[2*i +: 2]       <= w_cause[i];
        end
      end
    end
  end

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_busy[i] = (r_state[i] == S_WAIT);
    end
  end

  assign bus.pass_pulse = r_pass_pulse;
  assign bus.fail_pulse = r_fail_pulse;
  assign bus.err_sticky = r_err_sticky;
  assign bus.fail_cause = r_fail_cause;
  assign bus.pass_cnt   = r_pass_cnt;
  assign bus.fail_cnt   = r_fail_cnt;
  assign bus.busy       = w_busy;

`ifdef CHK_SVA_EN
  // Independent re-statement of the latency window for simulation logs
  for (genvar g = 0; g < NUM_CH; g++) begin : g_sva
    property p_ack_window;
      @(posedge clk) disable iff (!rst || !bus.enable || bus.clr)
        ($rose(bus.req[g]) && !bus.ack[g]) |-> ##[MIN_LAT:MAX_LAT] bus.ack[g];
    endproperty

    a_ack_window: assert property (p_ack_window)
      $display("ch%0d pass :: %0t", g, $time);
    else
      $display("ch%0d FAIL :: %0t", g, $time);
  end
`endif

endmodule
